string_serializer: RTL and testbench

STRING_SERIALIZER -- requirements
Module: string_serializer

---
 rtl/string_serializer_if.sv | 32 +++
 rtl/string_serializer.sv | 117 +++++++++++
 tb/tb_string_serializer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/string_serializer_if.sv
// Handshake bundle for string_serializer: the load request, the packed string,
// the per-character output stream and the end-of-string status.
interface string_serializer_if #(
  parameter int STR_LEN = 4,
  parameter int CODE_W  = 8
);
  localparam int IDX_W = (STR_LEN > 1) ? $clog2(STR_LEN) : 1;

  logic                 start;
  logic [8*STR_LEN-1:0] str;
  logic                 busy;
  logic                 out_valid;
  logic [CODE_W-1:0]    out_code;
  logic [IDX_W-1:0]     out_idx;
  logic                 out_last;
  logic                 bad_char;
  logic                 out_ready;
  logic                 done;
  logic [7:0]           err_count;

  // Serializer side: takes load requests and drives the character stream.
  modport slave (
    input  start, str, out_ready,
    output busy, out_valid, out_code, out_idx, out_last, bad_char, done, err_count
  );

  // Client side: issues strings and consumes the character stream.
  modport master (
    output start, str, out_ready,
    input  busy, out_valid, out_code, out_idx, out_last, bad_char, done, err_count
  );
endinterface

// File: rtl/string_serializer.sv
// Captures a packed string and emits it one character per beat, index 0 first,
// over a valid/ready stream. MODE=1 maps characters to an alphabet index
// (unmapped bytes become all-ones and are counted); MODE=0 passes raw bytes.
module string_serializer #(
  parameter int STR_LEN = 4,
  parameter int CODE_W  = 8,
  parameter int MODE    = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  string_serializer_if.slave bus
);
  localparam int IDX_W = (STR_LEN > 1) ? $clog2(STR_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STR_LEN - 1);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t               state_reg;
  state_t               state_next;
  logic [8*STR_LEN-1:0] str_reg;
  logic [IDX_W-1:0]     idx_reg;
  logic [7:0]           err_count_reg;

  logic [7:0]        chars [STR_LEN];
  logic [7:0]        cur_char;
  logic [CODE_W-1:0] code_raw;
  logic              bad_raw;
  logic              is_last;
  logic              fire;

  // Split the held string into per-character lanes for the index mux.
  for (genvar gi = 0; gi < STR_LEN; gi++) begin : g_chars
    assign chars[gi] = str_reg[8*gi +: 8];
  end

  if (STR_LEN == 1) begin : g_single
    assign cur_char = chars[0];
  end else begin : g_multi
    assign cur_char = chars[idx_reg];
  end

  assign is_last = (idx_reg == LAST_IDX);
  assign fire    = (state_reg == SEND) && bus.out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state: load from IDLE only, leave SEND on the final handshake,
  // and spend exactly one cycle in DONE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = SEND;
      SEND:    if (fire && is_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture on an accepted start, advance the index and count
  // unmapped characters on each transferred beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      str_reg       <= '0;
      idx_reg       <= '0;
      err_count_reg <= '0;
    end else if (state_reg == IDLE && bus.start) begin
      str_reg       <= bus.str;
      idx_reg       <= '0;
      err_count_reg <= '0;
    end else if (fire) begin
      if (!is_last) idx_reg <= idx_reg + 1'b1;
      if (bad_raw && err_count_reg != 8'hFF) err_count_reg <= err_count_reg + 8'd1;
    end
  end

  // Character encoding for the currently selected index.
  always_comb begin
    code_raw = '1;
    bad_raw  = 1'b0;
    if (MODE == 0) begin
      code_raw = CODE_W'(cur_char);
    end else if (cur_char >= 8'h41 && cur_char <= 8'h5A) begin   // 'A'..'Z'
      code_raw = CODE_W'(cur_char - 8'h40);
    end else if (cur_char >= 8'h61 && cur_char <= 8'h7A) begin   // 'a'..'z'
      code_raw = CODE_W'(cur_char - 8'h60);
    end else if (cur_char >= 8'h30 && cur_char <= 8'h39) begin   // '0'..'9' -> 27..36
      code_raw = CODE_W'(cur_char - 8'h15);
    end else if (cur_char == 8'h20) begin                        // space
      code_raw = '0;
    end else begin
      bad_raw = 1'b1;
    end
  end

  // Outputs derive from state so that reset clears them without a clock.
  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_code  = '0;
    bus.out_idx   = '0;
    bus.out_last  = 1'b0;
    bus.bad_char  = 1'b0;
    bus.busy      = (state_reg != IDLE);
    bus.done      = (state_reg == DONE);
    bus.err_count = err_count_reg;
    if (state_reg == SEND) begin
      bus.out_valid = 1'b1;
      bus.out_code  = code_raw;
      bus.out_idx   = idx_reg;
      bus.out_last  = is_last;
      bus.bad_char  = bad_raw;
    end
  end
endmodule

// File: tb/tb_string_serializer.sv
// Bench for string_serializer: an alphabet-index instance, a raw-byte instance
// (10-bit codes) driven in lockstep, and a one-character, 6-bit instance.
module tb_string_serializer;
  logic clk = 1'b0;
  logic rst_n;
  logic start, start1, out_ready;
  logic [31:0] str;
  logic [7:0]  str1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  string_serializer_if #(.STR_LEN(4), .CODE_W(8))  bus1 ();
  string_serializer_if #(.STR_LEN(4), .CODE_W(10)) bus0 ();
  string_serializer_if #(.STR_LEN(1), .CODE_W(6))  buss ();

  assign bus1.start = start;  assign bus1.str = str;  assign bus1.out_ready = out_ready;
  assign bus0.start = start;  assign bus0.str = str;  assign bus0.out_ready = out_ready;
  assign buss.start = start1; assign buss.str = str1; assign buss.out_ready = out_ready;

  string_serializer #(.STR_LEN(4), .CODE_W(8),  .MODE(1)) u_m1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  string_serializer #(.STR_LEN(4), .CODE_W(10), .MODE(0)) u_m0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  string_serializer #(.STR_LEN(1), .CODE_W(6),  .MODE(1)) u_s1 (.clk(clk), .rst_n(rst_n), .bus(buss));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference encoding by table lookup: {bad, code}.
  function automatic logic [16:0] ref_code(input logic [7:0] c, input int mode, input int cw);
    string up = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
    string lo = "abcdefghijklmnopqrstuvwxyz";
    string dg = "0123456789";
    logic [15:0] ones = 16'((32'd1 << cw) - 1);
    if (mode == 0) return {1'b0, 8'h00, c};
    if (c == 8'h20) return 17'd0;
    for (int i = 0; i < 26; i++)
      if (c == up[i] || c == lo[i]) return {1'b0, 16'(i + 1)};
    for (int i = 0; i < 10; i++)
      if (c == dg[i]) return {1'b0, 16'(27 + i)};
    return {1'b1, ones};
  endfunction

  function automatic logic [7:0] pick_char();
    case ($urandom_range(0, 4))
      0: return 8'(8'h41 + $urandom_range(0, 25));
      1: return 8'(8'h61 + $urandom_range(0, 25));
      2: return 8'(8'h30 + $urandom_range(0, 9));
      3: return 8'h20;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // Send one string to the lockstep pair and check every presented beat.
  // rmode: 0 always ready, 1 ready pattern 1,0,0,..., 2 random ready.
  task automatic run_str(input logic [31:0] s, input int rmode, input bit restart, input bit done_start);
    int k;
    int cyc;
    int nbad;
    bit rdy;
    logic [16:0] e1, e0;
    k = 0; cyc = 0; nbad = 0;
    @(negedge clk);
    chk("pre_busy", 32'(bus1.busy), 0);
    str = s; start = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (k < 4 && cyc < 100) begin
      e1 = ref_code(s[8*k +: 8], 1, 8);
      e0 = ref_code(s[8*k +: 8], 0, 10);
      chk("m1_valid", 32'(bus1.out_valid), 1);
      chk("m1_idx",   32'(bus1.out_idx), 32'(k));
      chk("m1_last",  32'(bus1.out_last), 32'(k == 3));
      chk("m1_code",  32'(bus1.out_code), 32'(e1[15:0]));
      chk("m1_bad",   32'(bus1.bad_char), 32'(e1[16]));
      chk("m1_busy",  32'(bus1.busy), 1);
      chk("m0_code",  32'(bus0.out_code), 32'(e0[15:0]));
      chk("m0_bad",   32'(bus0.bad_char), 0);
      if (restart && cyc == 1) begin
        start = 1'b1; str = ~s;
      end else begin
        start = 1'b0;
      end
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      @(negedge clk);
      if (rdy) begin
        nbad += int'(e1[16]);
        k++;
      end
      cyc++;
    end
    start = 1'b0;
    chk("beats", 32'(k), 4);
    chk("m1_valid_after", 32'(bus1.out_valid), 0);
    chk("m1_done", 32'(bus1.done), 1);
    chk("m1_busy_done", 32'(bus1.busy), 1);
    chk("m0_done", 32'(bus0.done), 1);
    if (done_start) begin
      start = 1'b1; str = ~s;
    end
    @(negedge clk);
    start = 1'b0;
    chk("m1_done_pulse", 32'(bus1.done), 0);
    chk("m1_idle_busy", 32'(bus1.busy), 0);
    chk("m1_err", 32'(bus1.err_count), 32'(nbad));
    chk("m0_err", 32'(bus0.err_count), 0);
    @(negedge clk);
    chk("m1_err_hold", 32'(bus1.err_count), 32'(nbad));
    $display("string %h rmode=%0d restart=%0d done_start=%0d beats=%0d errs=%0d",
             s, rmode, restart, done_start, k, nbad);
  endtask

  task automatic run_single(input logic [7:0] c);
    logic [16:0] e;
    e = ref_code(c, 1, 6);
    @(negedge clk);
    str1 = c; start1 = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("s1_valid", 32'(buss.out_valid), 1);
    chk("s1_idx",   32'(buss.out_idx), 0);
    chk("s1_last",  32'(buss.out_last), 1);
    chk("s1_code",  32'(buss.out_code), 32'(e[15:0]));
    chk("s1_bad",   32'(buss.bad_char), 32'(e[16]));
    @(negedge clk);
    chk("s1_done",  32'(buss.done), 1);
    chk("s1_vdrop", 32'(buss.out_valid), 0);
    @(negedge clk);
    chk("s1_err",   32'(buss.err_count), 32'(e[16]));
    $display("single char %h code=%h bad=%0d", c, e[15:0], e[16]);
  endtask

  initial begin
    logic [31:0] s;
    rst_n = 1'b0; start = 1'b0; start1 = 1'b0; out_ready = 1'b0; str = '0; str1 = '0;
    #12;
    chk("rst_valid", 32'(bus1.out_valid), 0);
    chk("rst_code",  32'(bus1.out_code), 0);
    chk("rst_idx",   32'(bus1.out_idx), 0);
    chk("rst_last",  32'(bus1.out_last), 0);
    chk("rst_bad",   32'(bus1.bad_char), 0);
    chk("rst_busy",  32'(bus1.busy), 0);
    chk("rst_done",  32'(bus1.done), 0);
    chk("rst_err",   32'(bus1.err_count), 0);
    @(negedge clk);
    rst_n = 1'b1;

    s = "ABCD"; run_str(s, 0, 1'b0, 1'b0);
    s = "a#9 "; run_str(s, 0, 1'b0, 1'b0);
    s = "HI!?"; run_str(s, 0, 1'b0, 1'b0);
    s = "ABCD"; run_str(s, 1, 1'b0, 1'b0);
    s = "ABCD"; run_str(s, 0, 1'b1, 1'b1);

    // Reset after the first beat has transferred.
    @(negedge clk);
    s = "WXYZ"; str = s; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_rst_idx", 32'(bus1.out_idx), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus1.out_valid), 0);
    chk("arst_code",  32'(bus1.out_code), 0);
    chk("arst_idx",   32'(bus1.out_idx), 0);
    chk("arst_busy",  32'(bus1.busy), 0);
    chk("arst_done",  32'(bus1.done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_done", 32'(bus1.done), 0);
      chk("post_rst_busy", 32'(bus1.busy), 0);
    end
    $display("reset mid-string applied");
    s = "Q7 z"; run_str(s, 0, 1'b0, 1'b0);

    for (int n = 0; n < 12; n++) begin
      s = {pick_char(), pick_char(), pick_char(), pick_char()};
      run_str(s, 2, n[0], n[1]);
    end

    run_single(8'h4D);
    run_single(8'h39);
    run_single(8'h2A);
    for (int n = 0; n < 4; n++) run_single(pick_char());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
